taxi_axil_wr_reg_slice: RTL and testbench



---
 rtl/taxi_axil_wr_reg_slice_if.sv | 45 ++++
 rtl/taxi_axil_wr_reg_slice.sv | 193 +++++++++++++++++++
 tb/tb_taxi_axil_wr_reg_slice.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_axil_wr_reg_slice_if.sv
// AXI4-Lite write-path interface (AW, W, B) with slave and master modports.
interface taxi_axil_wr_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STRB_W    = DATA_W / 8,
    parameter bit          AWUSER_EN = 1'b0,
    parameter int unsigned AWUSER_W  = 1,
    parameter bit          WUSER_EN  = 1'b0,
    parameter int unsigned WUSER_W   = 1,
    parameter bit          BUSER_EN  = 1'b0,
    parameter int unsigned BUSER_W   = 1
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic [AWUSER_W-1:0] awuser;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
    logic [WUSER_W-1:0]  wuser;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic [BUSER_W-1:0]  buser;
    logic                bvalid;
    logic                bready;

    modport wr_slv (
        input  awaddr, awprot, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wuser, wvalid,
        output wready,
        output bresp, buser, bvalid,
        input  bready
    );

    modport wr_mst (
        output awaddr, awprot, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wuser, wvalid,
        input  wready,
        input  bresp, buser, bvalid,
        output bready
    );
endinterface

// File: rtl/taxi_axil_wr_reg_slice.sv
// AXI4-Lite write-path register slice: AW, W and B each independently bypassed,
// registered, or skid-buffered.

module taxi_axil_wr_reg_slice_ch #(
    parameter int unsigned REG_TYPE = 2,
    parameter int unsigned W        = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    if (REG_TYPE == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
    end else if (REG_TYPE == 1) begin : g_simple
        logic [W-1:0] out_data_q, out_data_d;
        logic         out_valid_q, out_valid_d;
        logic         in_ready_q, in_ready_d;

        // Single stage: accept only into an empty output register.
        always_comb begin
            out_data_d  = out_data_q;
            out_valid_d = out_valid_q;
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (in_valid && in_ready_q) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end
            in_ready_d = !out_valid_d;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b0;
            end else begin
                out_data_q  <= out_data_d;
                out_valid_q <= out_valid_d;
                in_ready_q  <= in_ready_d;
            end
        end

        assign out_data  = out_data_q;
        assign out_valid = out_valid_q;
        assign in_ready  = in_ready_q;
    end else begin : g_skid
        logic [W-1:0] out_data_q, out_data_d;
        logic [W-1:0] tmp_data_q, tmp_data_d;
        logic         out_valid_q, out_valid_d;
        logic         tmp_valid_q, tmp_valid_d;
        logic         in_ready_q, in_ready_d;

        // in_ready_q high implies temp is empty; a stalled output diverts the beat to temp.
        always_comb begin
            out_data_d  = out_data_q;
            out_valid_d = out_valid_q;
            tmp_data_d  = tmp_data_q;
            tmp_valid_d = tmp_valid_q;
            if (in_ready_q) begin
                if (out_ready || !out_valid_q) begin
                    out_valid_d = in_valid;
                    if (in_valid) begin
                        out_data_d = in_data;
                    end
                end else if (in_valid) begin
                    tmp_valid_d = 1'b1;
                    tmp_data_d  = in_data;
                end
            end else if (out_ready && tmp_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = tmp_data_q;
                tmp_valid_d = 1'b0;
            end
            in_ready_d = !tmp_valid_d;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
                tmp_data_q  <= '0;
                tmp_valid_q <= 1'b0;
                in_ready_q  <= 1'b0;
            end else begin
                out_data_q  <= out_data_d;
                out_valid_q <= out_valid_d;
                tmp_data_q  <= tmp_data_d;
                tmp_valid_q <= tmp_valid_d;
                in_ready_q  <= in_ready_d;
            end
        end

        assign out_data  = out_data_q;
        assign out_valid = out_valid_q;
        assign in_ready  = in_ready_q;
    end
endmodule

module taxi_axil_wr_reg_slice #(
    parameter int unsigned AW_REG_TYPE = 2,
    parameter int unsigned W_REG_TYPE  = 2,
    parameter int unsigned B_REG_TYPE  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    taxi_axil_wr_if.wr_slv s_axil_wr,
    taxi_axil_wr_if.wr_mst m_axil_wr
);
    localparam int unsigned DATA_W   = s_axil_wr.DATA_W;
    localparam int unsigned ADDR_W   = s_axil_wr.ADDR_W;
    localparam int unsigned STRB_W   = s_axil_wr.STRB_W;
    localparam int unsigned AWUSER_W = s_axil_wr.AWUSER_W;
    localparam int unsigned WUSER_W  = s_axil_wr.WUSER_W;
    localparam int unsigned BUSER_W  = s_axil_wr.BUSER_W;
    localparam bit AWUSER_EN = s_axil_wr.AWUSER_EN && m_axil_wr.AWUSER_EN;
    localparam bit WUSER_EN  = s_axil_wr.WUSER_EN && m_axil_wr.WUSER_EN;
    localparam bit BUSER_EN  = s_axil_wr.BUSER_EN && m_axil_wr.BUSER_EN;

    localparam int unsigned AW_PL_W = ADDR_W + 3 + AWUSER_W;
    localparam int unsigned W_PL_W  = DATA_W + STRB_W + WUSER_W;
    localparam int unsigned B_PL_W  = 2 + BUSER_W;

    if (m_axil_wr.DATA_W != DATA_W || m_axil_wr.ADDR_W != ADDR_W ||
        m_axil_wr.STRB_W != STRB_W || m_axil_wr.AWUSER_W != AWUSER_W ||
        m_axil_wr.WUSER_W != WUSER_W || m_axil_wr.BUSER_W != BUSER_W) begin : g_width_chk
        $fatal(0, "taxi_axil_wr_reg_slice: s_axil_wr and m_axil_wr widths differ");
    end

    logic [AW_PL_W-1:0]  aw_in_c, aw_out_c;
    logic [W_PL_W-1:0]   w_in_c, w_out_c;
    logic [B_PL_W-1:0]   b_in_c, b_out_c;
    logic [AWUSER_W-1:0] awuser_c;
    logic [WUSER_W-1:0]  wuser_c;
    logic [BUSER_W-1:0]  buser_c;

    // User sidebands are zeroed unless both sides carry them.
    assign awuser_c = AWUSER_EN ? s_axil_wr.awuser : '0;
    assign wuser_c  = WUSER_EN ? s_axil_wr.wuser : '0;
    assign buser_c  = BUSER_EN ? m_axil_wr.buser : '0;

    assign aw_in_c = {s_axil_wr.awaddr, s_axil_wr.awprot, awuser_c};
    assign w_in_c  = {s_axil_wr.wdata, s_axil_wr.wstrb, wuser_c};
    assign b_in_c  = {m_axil_wr.bresp, buser_c};

    assign {m_axil_wr.awaddr, m_axil_wr.awprot, m_axil_wr.awuser} = aw_out_c;
    assign {m_axil_wr.wdata, m_axil_wr.wstrb, m_axil_wr.wuser}    = w_out_c;
    assign {s_axil_wr.bresp, s_axil_wr.buser}                     = b_out_c;

    taxi_axil_wr_reg_slice_ch #(.REG_TYPE(AW_REG_TYPE), .W(AW_PL_W)) u_aw (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (aw_in_c),
        .in_valid  (s_axil_wr.awvalid),
        .in_ready  (s_axil_wr.awready),
        .out_data  (aw_out_c),
        .out_valid (m_axil_wr.awvalid),
        .out_ready (m_axil_wr.awready)
    );

    taxi_axil_wr_reg_slice_ch #(.REG_TYPE(W_REG_TYPE), .W(W_PL_W)) u_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (w_in_c),
        .in_valid  (s_axil_wr.wvalid),
        .in_ready  (s_axil_wr.wready),
        .out_data  (w_out_c),
        .out_valid (m_axil_wr.wvalid),
        .out_ready (m_axil_wr.wready)
    );

    // Response channel runs upstream: m side is the input.
    taxi_axil_wr_reg_slice_ch #(.REG_TYPE(B_REG_TYPE), .W(B_PL_W)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_c),
        .in_valid  (m_axil_wr.bvalid),
        .in_ready  (m_axil_wr.bready),
        .out_data  (b_out_c),
        .out_valid (s_axil_wr.bvalid),
        .out_ready (s_axil_wr.bready)
    );
endmodule

// File: tb/tb_taxi_axil_wr_reg_slice.sv
// Scoreboard bench for taxi_axil_wr_reg_slice: default config (AW/W skid, B simple) plus an all-bypass instance.
module tb_taxi_axil_wr_reg_slice;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [1:0]  exp_b[$];
    logic        aw_stall, w_stall;
    logic [31:0] aw_hold, w_hold;

    taxi_axil_wr_if #(.DATA_W(32), .ADDR_W(32)) s_if ();
    taxi_axil_wr_if #(.DATA_W(32), .ADDR_W(32)) m_if ();
    taxi_axil_wr_if #(.DATA_W(32), .ADDR_W(32), .AWUSER_EN(1'b1)) s0_if ();
    taxi_axil_wr_if #(.DATA_W(32), .ADDR_W(32)) m0_if ();

    taxi_axil_wr_reg_slice dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axil_wr (s_if),
        .m_axil_wr (m_if)
    );

    taxi_axil_wr_reg_slice #(.AW_REG_TYPE(0), .W_REG_TYPE(0), .B_REG_TYPE(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axil_wr (s0_if),
        .m_axil_wr (m0_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want nothing", nm, act);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        s_if.awvalid = 1'b1;
        s_if.awaddr  = a;
        exp_aw.push_back(a);
        @(negedge clk);
        while (!s_if.awready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!s_if.awready) note_fail("aw_send_timeout", 64'(a));
        sync();
        s_if.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d);
        int n = 0;
        s_if.wvalid = 1'b1;
        s_if.wdata  = d;
        exp_w.push_back(d);
        @(negedge clk);
        while (!s_if.wready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!s_if.wready) note_fail("w_send_timeout", 64'(d));
        sync();
        s_if.wvalid = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] r);
        int n = 0;
        m_if.bvalid = 1'b1;
        m_if.bresp  = r;
        exp_b.push_back(r);
        @(negedge clk);
        while (!m_if.bready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!m_if.bready) note_fail("b_send_timeout", 64'(r));
        sync();
        m_if.bvalid = 1'b0;
    endtask

    // Output monitors for the registered instance: order, stability under stall, no extra beats.
    always @(negedge clk) begin
        if (rst_n) begin
            if (aw_stall) chk("aw_hold", 64'({m_if.awvalid, m_if.awaddr}), 64'({1'b1, aw_hold}));
            if (m_if.awvalid && m_if.awready) begin
                if (exp_aw.size() == 0) note_fail("aw_extra", 64'(m_if.awaddr));
                else chk("aw_data", 64'(m_if.awaddr), 64'(exp_aw.pop_front()));
            end
            aw_stall <= m_if.awvalid && !m_if.awready;
            aw_hold  <= m_if.awaddr;
        end else begin
            aw_stall <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (w_stall) chk("w_hold", 64'({m_if.wvalid, m_if.wdata}), 64'({1'b1, w_hold}));
            if (m_if.wvalid && m_if.wready) begin
                if (exp_w.size() == 0) note_fail("w_extra", 64'(m_if.wdata));
                else chk("w_data", 64'(m_if.wdata), 64'(exp_w.pop_front()));
            end
            w_stall <= m_if.wvalid && !m_if.wready;
            w_hold  <= m_if.wdata;
        end else begin
            w_stall <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_if.bvalid && s_if.bready) begin
            if (exp_b.size() == 0) note_fail("b_extra", 64'(s_if.bresp));
            else chk("b_resp", 64'(s_if.bresp), 64'(exp_b.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q0_aw[$];
        logic [31:0] q0_w[$];
        logic [1:0]  q0_b[$];
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        aw_stall = 1'b0;
        w_stall  = 1'b0;
        aw_hold  = '0;
        w_hold   = '0;
        s_if.awaddr = '0; s_if.awprot = '0; s_if.awuser = '0; s_if.awvalid = 1'b0;
        s_if.wdata = '0; s_if.wstrb = 4'hF; s_if.wuser = '0; s_if.wvalid = 1'b0;
        s_if.bready = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        m_if.bresp = '0; m_if.buser = '0; m_if.bvalid = 1'b0;
        s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awuser = 1'b1; s0_if.awvalid = 1'b0;
        s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wuser = '0; s0_if.wvalid = 1'b0;
        s0_if.bready = 1'b0;
        m0_if.awready = 1'b0; m0_if.wready = 1'b0;
        m0_if.bresp = '0; m0_if.buser = '0; m0_if.bvalid = 1'b0;

        // Reset values and ready ramp after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_awvalid", 64'(m_if.awvalid), 64'(0));
        chk("rst_m_wvalid", 64'(m_if.wvalid), 64'(0));
        chk("rst_m_bready", 64'(m_if.bready), 64'(0));
        chk("rst_s_awready", 64'(s_if.awready), 64'(0));
        chk("rst_s_wready", 64'(s_if.wready), 64'(0));
        chk("rst_s_bvalid", 64'(s_if.bvalid), 64'(0));
        chk("rst_s_bresp", 64'(s_if.bresp), 64'(0));
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel1_readies", 64'({s_if.awready, s_if.wready, m_if.bready}), 64'(3'b000));
        @(negedge clk);
        chk("rel2_readies", 64'({s_if.awready, s_if.wready, m_if.bready}), 64'(3'b111));

        // Skid AW: 8 back-to-back beats, one cycle latency, no bubbles.
        sync();
        m_if.awready = 1'b1;
        s_if.awvalid = 1'b1;
        s_if.awaddr  = 32'h0;
        exp_aw.push_back(32'h0);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) chk("aw_stream", 64'({m_if.awvalid, m_if.awaddr}), 64'({1'b1, 32'(4 * (i - 1))}));
            if (i < 8) begin
                chk("aw_s_ready", 64'(s_if.awready), 64'(1));
                sync();
                if (i < 7) begin
                    s_if.awaddr = 32'(4 * (i + 1));
                    exp_aw.push_back(32'(4 * (i + 1)));
                end else begin
                    s_if.awvalid = 1'b0;
                end
            end
        end

        // Skid W backpressure: two beats held, then drained in order.
        repeat (3) sync();
        m_if.wready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_w(32'hA0 + 32'(i));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("w_full_ready", 64'(s_if.wready), 64'(0));
                chk("w_full_out", 64'({m_if.wvalid, m_if.wdata}), 64'({1'b1, 32'hA0}));
                sync();
                m_if.wready = 1'b1;
            end
        join
        repeat (4) sync();
        chk("w_drained", 64'(exp_w.size()), 64'(0));

        // Simple B: bvalid every second cycle, bready alternating.
        s_if.bready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) send_b(2'b10);
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk("b_pulse", 64'({s_if.bvalid, m_if.bready}), 64'((k % 2 == 1) ? 2'b10 : 2'b01));
                    if (k % 2 == 1) chk("b_pulse_resp", 64'(s_if.bresp), 64'(2'b10));
                end
            end
        join
        send_b(2'b01);
        send_b(2'b11);
        repeat (3) sync();
        chk("b_drained", 64'(exp_b.size()), 64'(0));

        // W leads AW: W fills out + temp while AW remains open.
        m_if.wready  = 1'b0;
        m_if.awready = 1'b1;
        fork
            begin
                send_w(32'hC0);
                send_w(32'hC1);
                send_w(32'hC2);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("dec_w_full", 64'(s_if.wready), 64'(0));
                chk("dec_aw_open", 64'(s_if.awready), 64'(1));
                sync();
                s_if.awvalid = 1'b1;
                s_if.awaddr  = 32'h40;
                exp_aw.push_back(32'h40);
                @(negedge clk);
                chk("dec_aw_ready", 64'(s_if.awready), 64'(1));
                sync();
                s_if.awvalid = 1'b0;
                @(negedge clk);
                chk("dec_aw_out", 64'({m_if.awvalid, m_if.awaddr}), 64'({1'b1, 32'h40}));
                repeat (2) @(posedge clk);
                #1;
                m_if.wready = 1'b1;
            end
        join
        repeat (6) sync();
        chk("dec_drained", 64'(exp_w.size() + exp_aw.size()), 64'(0));

        // Reset with out and temp full on AW and W.
        m_if.wready  = 1'b0;
        m_if.awready = 1'b0;
        send_w(32'hD0);
        send_w(32'hD1);
        send_aw(32'h80);
        send_aw(32'h84);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'({m_if.awvalid, m_if.wvalid}), 64'(2'b00));
        chk("rst_async_ready", 64'({s_if.awready, s_if.wready}), 64'(2'b00));
        exp_w.delete();
        exp_aw.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_if.wready  = 1'b1;
        m_if.awready = 1'b1;
        @(negedge clk);
        chk("rst_rel1", 64'({s_if.awready, s_if.wready, m_if.bready}), 64'(3'b000));
        @(negedge clk);
        chk("rst_rel2", 64'({s_if.awready, s_if.wready, m_if.bready}), 64'(3'b111));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'({m_if.awvalid, m_if.wvalid}), 64'(2'b00));
        end

        // All-bypass instance: random valid/ready against a reference queue model.
        for (int i = 0; i < 60; i++) begin
            sync();
            s0_if.awvalid = 1'($urandom);
            s0_if.awaddr  = $urandom;
            s0_if.awprot  = 3'($urandom);
            s0_if.wvalid  = 1'($urandom);
            s0_if.wdata   = $urandom;
            s0_if.wstrb   = 4'($urandom);
            s0_if.bready  = 1'($urandom);
            m0_if.awready = 1'($urandom);
            m0_if.wready  = 1'($urandom);
            m0_if.bvalid  = 1'($urandom);
            m0_if.bresp   = 2'($urandom);
            @(negedge clk);
            if (s0_if.awvalid && m0_if.awready) q0_aw.push_back(s0_if.awaddr);
            if (s0_if.wvalid && m0_if.wready) q0_w.push_back(s0_if.wdata);
            if (m0_if.bvalid && s0_if.bready) q0_b.push_back(m0_if.bresp);
            chk("byp_hs", 64'({m0_if.awvalid, s0_if.awready, m0_if.wvalid, s0_if.wready, s0_if.bvalid, m0_if.bready}),
                64'({s0_if.awvalid, m0_if.awready, s0_if.wvalid, m0_if.wready, m0_if.bvalid, s0_if.bready}));
            chk("byp_aw_pl", 64'({m0_if.awprot, m0_if.awuser}), 64'({s0_if.awprot, 1'b0}));
            chk("byp_wstrb", 64'(m0_if.wstrb), 64'(s0_if.wstrb));
            if (m0_if.awvalid && m0_if.awready) begin
                if (q0_aw.size() == 0) note_fail("byp_aw_extra", 64'(m0_if.awaddr));
                else chk("byp_aw", 64'(m0_if.awaddr), 64'(q0_aw.pop_front()));
            end
            if (m0_if.wvalid && m0_if.wready) begin
                if (q0_w.size() == 0) note_fail("byp_w_extra", 64'(m0_if.wdata));
                else chk("byp_w", 64'(m0_if.wdata), 64'(q0_w.pop_front()));
            end
            if (s0_if.bvalid && s0_if.bready) begin
                if (q0_b.size() == 0) note_fail("byp_b_extra", 64'(s0_if.bresp));
                else chk("byp_b", 64'(s0_if.bresp), 64'(q0_b.pop_front()));
            end
        end
        chk("byp_left", 64'(q0_aw.size() + q0_w.size() + q0_b.size()), 64'(0));

        repeat (4) sync();
        chk("final_left", 64'(exp_aw.size() + exp_w.size() + exp_b.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
